// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, default
// memory depth and a helper deciding when the CPU must be held in reset.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  localparam int DEFAULT_MAX_WORDS = 256;

  // Hold the CPU while a load is in flight or has failed.
  function automatic logic hold_in_state(loader_state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) ||
           (s == WRITE)  || (s == ERR);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts serial bytes into a 32-bit word, first byte landing in [31:24].
// word_full_o is high in the cycle the 4th byte of a word is being shifted.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0] idx_q;

  // Shift register and byte index; clear only restarts the index since a
  // full word always overwrites every byte before it is used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_o <= '0;
      idx_q  <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
    end else if (shift_i) begin
      word_o <= {word_o[23:0], byte_i};
      idx_q  <= idx_q + 2'd1;
    end
  end

  assign word_full_o = shift_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Serial program loader: receives a 16-bit big-endian word count followed
// by big-endian 32-bit words and writes them to instruction memory from
// address 0, holding the CPU in reset until the load completes.
//
// Byte handshake: a byte moves on a rising clk_i edge where byte_valid_i and
// byte_ready_o are both 1; byte_ready_o depends only on the current state,
// never on byte_valid_i, and the source may hold byte_valid_i low for any
// number of cycles without disturbing partial state.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  loader_state_t state_q, state_d;
  logic [7:0]    hdr_hi_q;
  logic [15:0]   count_q;
  logic [15:0]   words_done_q;
  logic          clear;
  logic          shift;
  logic          word_full;
  logic [15:0]   hdr_count;
  logic          hdr_too_big;
  logic          last_word;

  assign hdr_count   = {hdr_hi_q, byte_data_i};
  assign hdr_too_big = {16'd0, hdr_count} > 32'(MAX_WORDS);
  assign last_word   = (words_done_q + 16'd1) == count_q;
  assign shift       = (state_q == DATA) && byte_valid_i;
  assign state_o     = state_q;

  byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .shift_i     (shift),
    .byte_i      (byte_data_i),
    .word_o      (im_wdata_o),
    .word_full_o (word_full)
  );

  // Next-state and Moore-style outputs.
  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    im_we_o      = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    clear        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = HDR_HI;
          clear   = 1'b1;
        end
      end
      HDR_HI: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = HDR_LO;
      end
      HDR_LO: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          if (hdr_count == 16'd0)  state_d = DONE;
          else if (hdr_too_big)    state_d = ERR;
          else                     state_d = DATA;
        end
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        im_we_o = 1'b1;
        state_d = last_word ? DONE : DATA;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_o = 1'b1;
        if (start_i) begin
          state_d = HDR_HI;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, header capture, word/address counters and CPU hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hdr_hi_q     <= '0;
      count_q      <= '0;
      words_done_q <= '0;
      im_addr_o    <= '0;
      cpu_hold_o   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cpu_hold_o <= hold_in_state(state_d);
      if (clear) begin
        count_q      <= '0;
        words_done_q <= '0;
        im_addr_o    <= '0;
      end
      if (state_q == HDR_HI && byte_valid_i) hdr_hi_q <= byte_data_i;
      if (state_q == HDR_LO && byte_valid_i) count_q  <= hdr_count;
      if (state_q == WRITE) begin
        words_done_q <= words_done_q + 16'd1;
        im_addr_o    <= im_addr_o + 32'd4;
      end
    end
  end

endmodule
